serial_tx_scheduler: RTL and testbench
======================================

SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 Parameter GAP, default 1: idle cycles inserted after each frame before a new grant (range 0..15).
REQ-002 Parameter FILL, default 1'b0: constant value driven on shSIn.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req0  input  1  requester 0 has a byte to send; held high until ack0.
REQ-006 data0  input  8  requester 0 byte; stable while req0 high.
REQ-007 ack0  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-008 req1  input  1  requester 1 has a byte to send; held high until ack1.
REQ-009 data1  input  8  requester 1 byte; stable while req1 high.
REQ-010 ack1  output  1  one-cycle pulse: requester 1 byte accepted.
REQ-011 shLoad  output  1  load strobe to the parallel-to-serial shifter.
REQ-012 shData  output  8  registered byte presented to the shifter's parallel input.
REQ-013 shSIn  output  1  serial fill bit to the shifter; always FILL.
REQ-014 txValid  output  1  high exactly while the shifter's serial output carries a frame bit.
REQ-015 txSel  output  1  index of requester owning the current or last frame.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-018 States: IDLE, LOAD, SHIFT, GAP; all outputs registered, decoded from state and counters.
REQ-019 IDLE: if req0 or req1 sampled high, grant one, capture its data into shData, set txSel, go to LOAD; else stay.
REQ-020 Arbitration round-robin: both requesting -> grant the requester not granted last; single requester -> grant it regardless of history.
REQ-021 Round-robin pointer after reset favours requester 0.
REQ-022 LOAD lasts exactly 1 cycle: shLoad=1, ackN=1 for the granted requester only, shData stable; then go to SHIFT.
REQ-023 Requests sampled outside IDLE are ignored (no ack, no capture); they are served once IDLE is re-entered.
REQ-024 A request dropped before its ack is never granted and causes no frame.
REQ-025 SHIFT lasts exactly 8 cycles, 3-bit counter 0..7, txValid=1, shLoad=0; shifter output in SHIFT cycle k equals shData[7-k] (MSB first).
REQ-026 After SHIFT count 7: go to GAP if GAP>0, else IDLE; counter wraps to 0.
REQ-027 done=1 for exactly the first cycle after the 8th SHIFT cycle (first GAP cycle, or IDLE when GAP=0).
REQ-028 GAP lasts exactly GAP cycles with txValid=0, shLoad=0, then IDLE.
REQ-029 Back-to-back frames with continuous requests: request-to-request period = 10+GAP cycles (IDLE 1, LOAD 1, SHIFT 8, GAP).
REQ-030 shData holds the last captured byte until the next grant; txSel holds until the next grant.
REQ-031 ack0 and ack1 never high in the same cycle; shLoad and txValid never high in the same cycle.

Reset
REQ-032 reset high on a clock edge -> state IDLE, counters 0, pointer favours requester 0, in any state including mid-SHIFT.
REQ-033 Reset values: ack0=0, ack1=0, shLoad=0, shData=8'h00, shSIn=FILL, txValid=0, txSel=0, busy=0, done=0.
REQ-034 A frame aborted by reset produces no done pulse and is not retried; its requester has already been acked.
REQ-035 reset has priority over every request and state transition in the same cycle.

Verification
REQ-036 Single send: GAP=1, req0=1, data0=8'hA5 in IDLE -> ack0 and shLoad high next cycle, then 8 txValid cycles with serial bits 1,0,1,0,0,1,0,1, done 1 cycle after.
REQ-037 Contention: req0 and req1 high together after reset, data0=8'h0F, data1=8'hF0 -> frame 1 txSel=0 (0F), frame 2 txSel=1 (F0), second LOAD exactly 11 cycles after first.
REQ-038 Fairness: both requesters held high for 4 frames -> grants alternate 0,1,0,1; no ack on the non-granted line.
REQ-039 GAP=0: req1 held high with 8'h81 -> LOAD cycles 10 cycles apart, done coincides with IDLE cycle.
REQ-040 Reset mid-frame: assert reset in SHIFT count 3 -> next cycle txValid=0, busy=0, state IDLE, no done; pending req0 then granted with ack0.
REQ-041 Late request: req1 rises during SHIFT of a requester-0 frame -> no ack1 until IDLE; then granted with txSel=1.

Source files
------------

// File: rtl/serial_tx_scheduler_if.sv
// Requester/shifter bundle for serial_tx_scheduler. The scheduler connects
// through the slave modport; requesters and shifter use the master modport.
interface serial_tx_scheduler_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       shLoad;
  logic [7:0] shData;
  logic       shSIn;
  logic       txValid;
  logic       txSel;
  logic       busy;
  logic       done;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, shLoad, shData, shSIn, txValid, txSel, busy, done
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, shLoad, shData, shSIn, txValid, txSel, busy, done
  );
endinterface

// File: rtl/serial_tx_scheduler.sv
// Two-requester round-robin scheduler that feeds one byte at a time to an
// external parallel-to-serial shifter (MSB first), followed by GAP idle cycles.
module serial_tx_scheduler #(
  parameter int unsigned GAP  = 1,
  parameter logic        FILL = 1'b0
) (
  input logic                   clk,
  input logic                   reset,
  serial_tx_scheduler_if.slave  io_bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  logic [1:0] r_state;
  logic [2:0] r_bitCnt;
  logic [3:0] r_gapCnt;
  logic       r_lastSel;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_shLoad;
  logic [7:0] r_shData;
  logic       r_txValid;
  logic       r_txSel;
  logic       r_busy;
  logic       r_done;

  logic       w_reqAny;
  logic       w_grantSel;
  logic       w_grant;
  logic [1:0] w_stateNxt;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    w_reqAny = io_bus.req0 | io_bus.req1;
    if (io_bus.req0 && io_bus.req1) begin
      w_grantSel = ~r_lastSel;
    end else begin
      w_grantSel = io_bus.req1;
    end
    w_grant = (r_state == S_IDLE) && w_reqAny;
  end

  always_comb begin
    w_stateNxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_reqAny) w_stateNxt = S_LOAD;
      S_LOAD:  w_stateNxt = S_SHIFT;
      S_SHIFT: if (r_bitCnt == 3'd7) w_stateNxt = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gapCnt == GAP_LAST) w_stateNxt = S_IDLE;
      default: w_stateNxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bitCnt  <= '0;
      r_gapCnt  <= '0;
      r_lastSel <= 1'b1;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_shLoad  <= 1'b0;
      r_shData  <= '0;
      r_txValid <= 1'b0;
      r_txSel   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_bitCnt  <= (r_state == S_SHIFT) ? r_bitCnt + 3'd1 : 3'd0;
      r_gapCnt  <= (r_state == S_GAP && w_stateNxt == S_GAP) ? r_gapCnt + 4'd1 : 4'd0;
      if (w_grant) begin
        r_shData  <= w_grantSel ? io_bus.data1 : io_bus.data0;
        r_txSel   <= w_grantSel;
        r_lastSel <= w_grantSel;
      end
      r_ack0    <= w_grant && !w_grantSel;
      r_ack1    <= w_grant && w_grantSel;
      r_shLoad  <= (w_stateNxt == S_LOAD);
      r_txValid <= (w_stateNxt == S_SHIFT);
      r_busy    <= (w_stateNxt != S_IDLE);
      r_done    <= (r_state == S_SHIFT) && (r_bitCnt == 3'd7);
    end
  end

  assign io_bus.ack0    = r_ack0;
  assign io_bus.ack1    = r_ack1;
  assign io_bus.shLoad  = r_shLoad;
  assign io_bus.shData  = r_shData;
  assign io_bus.shSIn   = FILL;
  assign io_bus.txValid = r_txValid;
  assign io_bus.txSel   = r_txSel;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;

  a_ack_onehot: assert property (@(posedge clk) !(r_ack0 && r_ack1));
  a_load_tx_excl: assert property (@(posedge clk) !(r_shLoad && r_txValid));

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: table of single-frame vectors, scoreboarded
// frame monitor with a shifter model, and hand sequences for timing corners.
module tb_serial_tx_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  serial_tx_scheduler_if b1();
  serial_tx_scheduler_if b0();

  serial_tx_scheduler #(.GAP(1), .FILL(1'b0)) u_dut1 (.clk(clk), .reset(reset), .io_bus(b1));
  serial_tx_scheduler #(.GAP(0), .FILL(1'b1)) u_dut0 (.clk(clk), .reset(reset), .io_bus(b0));

  // Shifter models: load on shLoad, otherwise shift left taking the fill bit.
  logic [7:0] sr1;
  logic [7:0] sr0;
  always_ff @(posedge clk) begin
    sr1 <= b1.shLoad ? b1.shData : {sr1[6:0], b1.shSIn};
    sr0 <= b0.shLoad ? b0.shData : {sr0[6:0], b0.shSIn};
  end

  typedef struct packed {
    logic       sel;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  exp_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not seen within cycle budget, got none, expected one", name);
  endtask

  task automatic push_exp(input logic sel, input logic [7:0] d);
    exp_t e;
    e.sel  = sel;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_idle1(input string name);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (!b1.busy) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_ack1(input string name, output int unsigned t, output logic sel);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (b1.ack0 || b1.ack1) begin
        t   = cyc;
        sel = b1.ack1;
        return;
      end
    end
    t   = 0;
    sel = 1'bx;
    timeout_fail(name);
  endtask

  // Frame monitor for the GAP=1 instance: pops the expected frame at each
  // load and checks the serial bits and the done pulse at frame end.
  initial begin : mon
    exp_t        cur;
    int unsigned cnt;
    logic [7:0]  bits;
    logic        in_frame;
    logic        prev_tx;
    logic        exp_done;
    cur = '0; cnt = 0; bits = '0; in_frame = 1'b0; prev_tx = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        in_frame = 1'b0;
        prev_tx  = 1'b0;
        cnt      = 0;
        continue;
      end
      check("mon_ack_excl", {b1.ack0, b1.ack1} == 2'b11, 1'b0);
      check("mon_load_tx_excl", b1.shLoad && b1.txValid, 1'b0);
      if (b1.shLoad) begin
        if (sb.size() == 0) begin
          timeout_fail("mon_unexpected_frame");
        end else begin
          cur = sb.pop_front();
          check("mon_txSel", b1.txSel, cur.sel);
          check("mon_shData", b1.shData, cur.data);
          check("mon_ack0", b1.ack0, !cur.sel);
          check("mon_ack1", b1.ack1, cur.sel);
        end
        in_frame = 1'b1;
        cnt = 0;
        bits = '0;
      end
      if (b1.txValid) begin
        bits = {bits[6:0], sr1[7]};
        cnt++;
      end
      exp_done = prev_tx && !b1.txValid;
      if (exp_done || b1.done) check("mon_done", b1.done, exp_done);
      if (exp_done && in_frame) begin
        check("mon_bitcount", cnt, 8);
        check("mon_serial", bits, cur.data);
        in_frame = 1'b0;
      end
      prev_tx = b1.txValid;
    end
  end

  initial begin : main
    vec_t        tbl[8];
    int unsigned t0;
    int unsigned t1;
    int unsigned t_prev;
    int unsigned nload;
    int unsigned ntx;
    logic        s;
    logic        found;
    logic        prev_tx;
    logic [7:0]  bits;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 8'hF0};
    tbl[2] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 8'h3C};
    tbl[3] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 8'h55};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h81, 1'b1, 8'h81};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h7E, 1'b1, 8'h7E};
    tbl[6] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 8'h12};
    tbl[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF};

    b1.req0 = 1'b0; b1.req1 = 1'b0; b1.data0 = '0; b1.data1 = '0;
    b0.req0 = 1'b0; b0.req1 = 1'b0; b0.data0 = '0; b0.data1 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", b1.ack0, 1'b0);
    check("rst_ack1", b1.ack1, 1'b0);
    check("rst_shLoad", b1.shLoad, 1'b0);
    check("rst_shData", b1.shData, 8'h00);
    check("rst_shSIn", b1.shSIn, 1'b0);
    check("rst_txValid", b1.txValid, 1'b0);
    check("rst_txSel", b1.txSel, 1'b0);
    check("rst_busy", b1.busy, 1'b0);
    check("rst_done", b1.done, 1'b0);
    check("rst_shSIn_fill1", b0.shSIn, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      wait_idle1("vec_idle");
      @(negedge clk);
      b1.req0 = tbl[i].r0; b1.data0 = tbl[i].d0;
      b1.req1 = tbl[i].r1; b1.data1 = tbl[i].d1;
      push_exp(tbl[i].exp_sel, tbl[i].exp_data);
      wait_ack1("vec_ack_wait", t0, s);
      check("vec_ack0", b1.ack0, !tbl[i].exp_sel);
      check("vec_ack1", b1.ack1, tbl[i].exp_sel);
      check("vec_shLoad", b1.shLoad, 1'b1);
      check("vec_txSel", b1.txSel, tbl[i].exp_sel);
      check("vec_shData", b1.shData, tbl[i].exp_data);
      check("vec_busy", b1.busy, 1'b1);
      @(negedge clk);
      b1.req0 = 1'b0; b1.req1 = 1'b0;
    end

    // Contention right after reset, held for four frames
    wait_idle1("rr_idle");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b1.req0 = 1'b1; b1.data0 = 8'h0F;
    b1.req1 = 1'b1; b1.data1 = 8'hF0;
    push_exp(1'b0, 8'h0F); push_exp(1'b1, 8'hF0);
    push_exp(1'b0, 8'h0F); push_exp(1'b1, 8'hF0);
    nload = 0; t_prev = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (b1.shLoad) begin
        check("rr_txSel", b1.txSel, nload[0]);
        check("rr_ack0", b1.ack0, !nload[0]);
        check("rr_ack1", b1.ack1, nload[0]);
        if (nload > 0) check("rr_period", cyc - t_prev, 11);
        t_prev = cyc;
        nload++;
        if (nload == 4) begin
          @(negedge clk);
          b1.req0 = 1'b0; b1.req1 = 1'b0;
          break;
        end
      end
    end
    if (nload != 4) timeout_fail("rr_four_frames");

    // Late request from requester 1 during a requester-0 frame
    wait_idle1("late_idle");
    @(negedge clk);
    b1.req0 = 1'b1; b1.data0 = 8'hC8;
    push_exp(1'b0, 8'hC8); push_exp(1'b1, 8'h3D);
    wait_ack1("late_ack0_wait", t0, s);
    check("late_first_sel", s, 1'b0);
    @(negedge clk);
    b1.req0 = 1'b0;
    repeat (3) @(negedge clk);
    b1.req1 = 1'b1; b1.data1 = 8'h3D;
    wait_ack1("late_ack1_wait", t1, s);
    check("late_second_sel", s, 1'b1);
    check("late_ack_spacing", t1 - t0, 11);
    check("late_txSel", b1.txSel, 1'b1);
    @(negedge clk);
    b1.req1 = 1'b0;

    // Reset in SHIFT count 3 with both requesters pending
    wait_idle1("mid_idle");
    @(negedge clk);
    b1.req0 = 1'b1; b1.data0 = 8'h96;
    push_exp(1'b0, 8'h96);
    wait_ack1("mid_ack_wait", t0, s);
    @(negedge clk);
    b1.req0 = 1'b0;
    ntx = 0; found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b1.txValid) ntx++;
      if (ntx == 4) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail("mid_shift3");
    @(negedge clk);
    reset = 1'b1;
    b1.req0 = 1'b1; b1.data0 = 8'h5A;
    b1.req1 = 1'b1; b1.data1 = 8'hE7;
    push_exp(1'b0, 8'h5A); push_exp(1'b1, 8'hE7);
    @(posedge clk); #1;
    check("mid_txValid", b1.txValid, 1'b0);
    check("mid_busy", b1.busy, 1'b0);
    check("mid_done", b1.done, 1'b0);
    check("mid_shLoad", b1.shLoad, 1'b0);
    check("mid_ack0", b1.ack0, 1'b0);
    check("mid_shData", b1.shData, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_regrant_ack0", b1.ack0, 1'b1);
    check("mid_regrant_ack1", b1.ack1, 1'b0);
    check("mid_regrant_data", b1.shData, 8'h5A);
    t0 = cyc;
    @(negedge clk);
    b1.req0 = 1'b0;
    wait_ack1("mid_ack1_wait", t1, s);
    check("mid_second_sel", s, 1'b1);
    check("mid_second_spacing", t1 - t0, 11);
    @(negedge clk);
    b1.req1 = 1'b0;

    // GAP=0 instance, requester 1 held continuously
    @(negedge clk);
    b0.req1 = 1'b1; b0.data1 = 8'h81;
    nload = 0; ntx = 0; bits = '0; t_prev = 0; prev_tx = 1'b0; found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (b0.txValid && nload == 1) begin
        bits = {bits[6:0], sr0[7]};
        ntx++;
      end
      if (prev_tx && !b0.txValid && nload == 1) begin
        check("g0_done", b0.done, 1'b1);
        check("g0_done_idle", b0.busy, 1'b0);
        check("g0_bitcount", ntx, 8);
        check("g0_serial", bits, 8'h81);
      end
      if (b0.shLoad) begin
        check("g0_ack1", b0.ack1, 1'b1);
        check("g0_ack0", b0.ack0, 1'b0);
        check("g0_txSel", b0.txSel, 1'b1);
        if (nload > 0) check("g0_period", cyc - t_prev, 10);
        t_prev = cyc;
        nload++;
        if (nload == 3) begin
          found = 1'b1;
          @(negedge clk);
          b0.req1 = 1'b0;
          break;
        end
      end
      prev_tx = b0.txValid;
    end
    if (!found) timeout_fail("g0_three_frames");

    wait_idle1("drain_idle");
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
